// File: rtl/awg_pkg.sv
// Shared constants, command codes and parser state encoding for the AWG command path.
package awg_pkg;
    localparam logic [7:0] HDR_BYTE  = 8'hA5;
    localparam logic [7:0] CMD_FREQ  = 8'h01;
    localparam logic [7:0] CMD_AMP   = 8'h02;
    localparam logic [7:0] CMD_PHASE = 8'h03;
    localparam logic [7:0] CMD_EN    = 8'h04;
    localparam logic [7:0] ACK_OK    = 8'h5A;
    localparam logic [7:0] ACK_ERR   = 8'hEE;

    localparam int FREQ_W  = 12;
    localparam int AMP_W   = 3;
    localparam int PHASE_W = 8;

    typedef enum logic [2:0] {IDLE, CMD, DHI, DLO, CHK} parse_state_t;
endpackage

// File: rtl/awg_frame_parser.sv
// Frame parser: header hunt, byte collection, inter-byte timeout and checksum test.
// Done/abort strobes are combinational on the CHK byte (or expiry) cycle so the owner can commit on that edge.
module awg_frame_parser
    import awg_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        timeout
);
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    parse_state_t     state_reg;
    logic [7:0]       cmd_reg;
    logic [7:0]       dhi_reg;
    logic [7:0]       dlo_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             in_frame;
    logic             chk_match;

    assign in_frame  = (state_reg != IDLE);
    assign chk_match = (rx_data == (cmd_reg ^ dhi_reg ^ dlo_reg));
    // A byte arriving on the expiry cycle wins, hence the !rx_valid term.
    assign timeout   = in_frame && !rx_valid && (cnt_reg == CNT_LAST);
    assign frame_ok  = (state_reg == CHK) && rx_valid && chk_match;
    assign frame_err = (state_reg == CHK) && rx_valid && !chk_match;
    assign cmd       = cmd_reg;
    assign data      = {dhi_reg, dlo_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cmd_reg   <= 8'h00;
            dhi_reg   <= 8'h00;
            dlo_reg   <= 8'h00;
            cnt_reg   <= '0;
        end else begin
            if (rx_valid || !in_frame || timeout)
                cnt_reg <= '0;
            else if (cnt_reg != CNT_LAST)
                cnt_reg <= cnt_reg + CNT_W'(1);

            if (timeout) begin
                state_reg <= IDLE;
            end else if (rx_valid) begin
                case (state_reg)
                    IDLE: if (rx_data == HDR_BYTE) state_reg <= CMD;
                    CMD: begin
                        cmd_reg   <= rx_data;
                        state_reg <= DHI;
                    end
                    DHI: begin
                        dhi_reg   <= rx_data;
                        state_reg <= DLO;
                    end
                    DLO: begin
                        dlo_reg   <= rx_data;
                        state_reg <= CHK;
                    end
                    CHK:     state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/awg_param_ctrl.sv
// Parameter register bank for the waveform generators, fed by checksum-validated command frames.
// Optional response channel enabled by defining AWG_CTRL_ACK_EN.
module awg_param_ctrl
    import awg_pkg::*;
#(
    parameter int                TIMEOUT_CYC = 50000,
    parameter logic [FREQ_W-1:0] FREQ_RST    = 12'd1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [FREQ_W-1:0]  state_freq,
    output logic [AMP_W-1:0]   state_amp,
    output logic [PHASE_W-1:0] state_phase,
    output logic               en,
    output logic               upd,
    output logic               err
`ifdef AWG_CTRL_ACK_EN
    ,
    output logic [7:0]         ack_data,
    output logic               ack_valid,
    input  logic               ack_ready
`endif
);
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        frame_ok;
    logic        frame_err;
    logic        timeout;
    logic        range_ok;
    logic        accept;
    logic        reject;

    awg_frame_parser #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_parser (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .cmd       (cmd),
        .data      (data),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .timeout   (timeout)
    );

    // Unknown commands fall to the default and are rejected like out-of-range values.
    always_comb begin
        range_ok = 1'b0;
        case (cmd)
            CMD_FREQ:  range_ok = (data <= 16'h0FFF);
            CMD_AMP:   range_ok = (data >= 16'd1) && (data <= 16'd7);
            CMD_PHASE: range_ok = (data <= 16'h00FF);
            CMD_EN:    range_ok = (data <= 16'd1);
            default:   range_ok = 1'b0;
        endcase
    end

    assign accept = frame_ok && range_ok;
    assign reject = frame_err || timeout || (frame_ok && !range_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_freq  <= FREQ_RST;
            state_amp   <= AMP_W'(1);
            state_phase <= '0;
            en          <= 1'b0;
            upd         <= 1'b0;
            err         <= 1'b0;
        end else begin
            upd <= accept;
            err <= reject;
            if (accept) begin
                case (cmd)
                    CMD_FREQ:  state_freq  <= data[FREQ_W-1:0];
                    CMD_AMP:   state_amp   <= data[AMP_W-1:0];
                    CMD_PHASE: state_phase <= data[PHASE_W-1:0];
                    CMD_EN:    en          <= data[0];
                    default:   ;
                endcase
            end
        end
    end

`ifdef AWG_CTRL_ACK_EN
    // Single-entry response buffer; a newer status overwrites an unconsumed one.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_valid <= 1'b0;
            ack_data  <= 8'h00;
        end else if (frame_ok || frame_err) begin
            ack_valid <= 1'b1;
            ack_data  <= accept ? ACK_OK : ACK_ERR;
        end else if (ack_ready) begin
            ack_valid <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_awg_param_ctrl.sv
// Self-checking bench for awg_param_ctrl: directed scenarios plus randomized frames against a frame-level model.
module tb_awg_param_ctrl;
    localparam int T = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [11:0] state_freq;
    logic [2:0]  state_amp;
    logic [7:0]  state_phase;
    logic        en, upd, err;
`ifdef AWG_CTRL_ACK_EN
    logic [7:0]  ack_data;
    logic        ack_valid;
`endif
    logic        ack_ready = 1'b0;

    always #5 clk = ~clk;

    awg_param_ctrl #(.TIMEOUT_CYC(T), .FREQ_RST(12'd1)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .state_freq  (state_freq),
        .state_amp   (state_amp),
        .state_phase (state_phase),
        .en          (en),
        .upd         (upd),
        .err         (err)
`ifdef AWG_CTRL_ACK_EN
        ,
        .ack_data    (ack_data),
        .ack_valid   (ack_valid),
        .ack_ready   (ack_ready)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    // Model: frame buffer of collected bytes plus idle-gap count, resolved whole-frame at a time.
    bit [7:0]  fb[$];
    int        gap = 0;
    bit [11:0] m_freq = 12'd1;
    bit [2:0]  m_amp = 3'd1;
    bit [7:0]  m_phase = 8'h00;
    bit        m_en = 0, m_upd = 0, m_err = 0;
    bit        m_ackv = 0;
    bit [7:0]  m_ackd = 8'h00;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit v, input bit [7:0] d);
        bit        ok, acc;
        bit [15:0] dv;
        bit        done = 0;
        m_upd = 0;
        m_err = 0;
        if (r) begin
            fb.delete(); gap = 0;
            m_freq = 12'd1; m_amp = 3'd1; m_phase = 8'h00; m_en = 0;
            m_ackv = 0; m_ackd = 8'h00;
            return;
        end
        if (v) begin
            gap = 0;
            if (fb.size() != 0 || d == 8'hA5) fb.push_back(d);
            if (fb.size() == 5) begin
                dv  = {fb[2], fb[3]};
                ok  = (fb[4] == (fb[1] ^ fb[2] ^ fb[3]));
                acc = 0;
                if (ok && fb[1] == 8'h01 && dv < 16'h1000) begin m_freq = dv[11:0]; acc = 1; end
                if (ok && fb[1] == 8'h02 && dv >= 1 && dv <= 7) begin m_amp = dv[2:0]; acc = 1; end
                if (ok && fb[1] == 8'h03 && dv < 16'h100) begin m_phase = dv[7:0]; acc = 1; end
                if (ok && fb[1] == 8'h04 && dv < 2) begin m_en = dv[0]; acc = 1; end
                m_upd = acc;
                m_err = !acc;
                m_ackv = 1;
                m_ackd = acc ? 8'h5A : 8'hEE;
                done = 1;
                fb.delete();
            end
        end else if (fb.size() != 0) begin
            gap++;
            if (gap == T) begin
                m_err = 1; fb.delete(); gap = 0;
            end
        end
        if (!done && m_ackv && ack_ready) m_ackv = 0;
    endtask

    task automatic step(input bit r, input bit v, input bit [7:0] d);
        @(negedge clk);
        rst = r; rx_valid = v; rx_data = d;
        model(r, v, d);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit [7:0] d);
        step(0, 1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00);
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (chk_en) begin
                check("freq", state_freq, m_freq);
                check("amp", state_amp, m_amp);
                check("phase", state_phase, m_phase);
                check("en", en, m_en);
                check("upd", upd, m_upd);
                check("err", err, m_err);
`ifdef AWG_CTRL_ACK_EN
                check("ack_valid", ack_valid, m_ackv);
                if (m_ackv) check("ack_data", ack_data, m_ackd);
`endif
            end
        end
    end

    initial begin
        bit [7:0] f[5];
        bit [15:0] dv;
        int sel, g;

        step(1, 0, 0);
        step(1, 0, 0);
        chk_en = 1;
        check("rst_freq", state_freq, 12'h001);
        check("rst_amp", state_amp, 3'd1);
        check("rst_en", en, 1'b0);

        // 1: frequency write, upd right after CHK byte
        step(0, 1, 8'hA5); send(8'h01); send(8'h02); send(8'h00);
        check("t1_upd_pre", upd, 1'b0);
        send(8'h03);
        check("t1_upd", upd, 1'b1);
        check("t1_freq", state_freq, 12'h200);
        check("t1_amp", state_amp, 3'd1);
        idle(1);
        check("t1_upd_drop", upd, 1'b0);

        // 2: AMP=0 rejected, AMP=4 accepted (back-to-back)
        send(8'hA5); send(8'h02); send(8'h00); send(8'h00); send(8'h02);
        check("t2_err", err, 1'b1);
        check("t2_amp_hold", state_amp, 3'd1);
        send(8'hA5); send(8'h02); send(8'h00); send(8'h04); send(8'h06);
        check("t2_upd", upd, 1'b1);
        check("t2_amp", state_amp, 3'd4);

        // 3: bad checksum, then good phase
        send(8'hA5); send(8'h03); send(8'h00); send(8'h40); send(8'hFF);
        check("t3_err", err, 1'b1);
        check("t3_phase_hold", state_phase, 8'h00);
        send(8'hA5); send(8'h03); send(8'h00); send(8'h40); send(8'h43);
        check("t3_phase", state_phase, 8'h40);

        // 4: timeout boundary, then a frame completes normally
        send(8'hA5); send(8'h04); send(8'h00);
        idle(T - 1);
        check("t4_no_err_early", err, 1'b0);
        idle(1);
        check("t4_err", err, 1'b1);
        send(8'hA5); send(8'h04); send(8'h00); send(8'h01); send(8'h05);
        check("t4_en", en, 1'b1);
        // byte on the expiry cycle wins
        send(8'hA5); send(8'h04); idle(T - 1); send(8'h00);
        check("t4_byte_wins", err, 1'b0);
        send(8'h00); send(8'h04);
        check("t4_en0", en, 1'b0);

        // 5: reset mid-frame, stray tail ignored
        send(8'hA5); send(8'h01); send(8'h00);
        step(1, 0, 0);
        send(8'h00); send(8'h03);
        check("t5_upd", upd, 1'b0);
        check("t5_err", err, 1'b0);
        check("t5_freq", state_freq, 12'h001);
        check("t5_amp", state_amp, 3'd1);

`ifdef AWG_CTRL_ACK_EN
        // 6: latest status wins, single handshake
        ack_ready = 0;
        send(8'hA5); send(8'h03); send(8'h00); send(8'h11); send(8'h12);
        send(8'hA5); send(8'h03); send(8'h00); send(8'h11); send(8'h00);
        idle(2);
        check("t6_ack_valid", ack_valid, 1'b1);
        check("t6_ack_data", ack_data, 8'hEE);
        ack_ready = 1;
        idle(1);
        check("t6_ack_done", ack_valid, 1'b0);
`endif

        // Randomized frames
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            f[1] = (sel < 2) ? 8'h01 : (sel < 4) ? 8'h02 : (sel < 6) ? 8'h03 :
                   (sel < 8) ? 8'h04 : (sel == 8) ? 8'h00 : 8'($urandom);
            dv = 16'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                case (f[1])
                    8'h01: dv = 16'($urandom_range(0, 16'h0FFF));
                    8'h02: dv = 16'($urandom_range(0, 7));
                    8'h03: dv = 16'($urandom_range(0, 255));
                    8'h04: dv = 16'($urandom_range(0, 1));
                    default: ;
                endcase
            end
            f[0] = 8'hA5; f[2] = dv[15:8]; f[3] = dv[7:0];
            f[4] = f[1] ^ f[2] ^ f[3];
            if ($urandom_range(0, 6) == 0) f[4] = f[4] ^ 8'(($urandom_range(1, 255)));
            for (int b = 0; b < 5; b++) begin
                send(f[b]);
                if ($urandom_range(0, 24) == 0)
                    idle(T - 1 + $urandom_range(0, 2));
                else if ($urandom_range(0, 5) == 0)
                    idle($urandom_range(1, 4));
                if ($urandom_range(0, 59) == 0) step(1, 0, 0);
            end
            ack_ready = 1'($urandom);
            if ($urandom_range(0, 9) == 0) send(8'($urandom));
            g = $urandom_range(0, 1);
            if (g != 0) idle(g);
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
